tick_gen_multi: RTL and testbench

Multi-channel programmable tick generator for the parking-slot controller, derived from the 100 MHz board clock. Each channel divides `clk_in` by a run-time programmable divisor and emits either a one-cycle strobe (for debouncing, display refresh, slot timers) or a near-50% square wave (for buzzers, LED blink). Divisor and mode changes are glitch-free: they take effect only at a period boundary or on a synchronous restart.

---
 rtl/tick_pkg.sv | 17 +
 rtl/tick_chan.sv | 95 +++++++++
 rtl/tick_gen_multi.sv | 44 ++++
 tb/tb_tick_gen_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the multi-channel tick generator: minimum divisor,
// output mode encoding and the divisor clamp used on reset and config writes.
package tick_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    TICK_PULSE  = 1'b0,
    TICK_SQUARE = 1'b1
  } tick_mode_e;

  // Divisors below MIN_DIV cannot produce a distinct high/low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: free-running counter with shadowed divisor/mode that are
// promoted to the active set only at a period boundary or a synchronous restart.
module tick_chan
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned DEF_DIV = 1_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  tick_mode_e       cfg_mode_i,
  output logic             clk_out_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(clamp_div(DEF_DIV));

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  tick_mode_e       mode_q, mode_d;
  tick_mode_e       sh_mode_q, sh_mode_d;
  logic             clk_out_q, clk_out_d;
  logic             wrap_q, wrap_d;

  logic [CNT_W-1:0] wr_div;
  logic [CNT_W-1:0] load_div;
  tick_mode_e       load_mode;
  logic             at_wrap;

  always_comb begin
    wr_div    = CNT_W'(clamp_div(32'(cfg_div_i)));
    at_wrap   = (count_q == (div_q - CNT_W'(1)));
    // A write coinciding with a boundary bypasses the shadow.
    load_div  = cfg_we_i ? wr_div : sh_div_q;
    load_mode = cfg_we_i ? cfg_mode_i : sh_mode_q;

    count_d   = count_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    clk_out_d = 1'b0;
    wrap_d    = 1'b0;

    if (sync_clr_i) begin
      count_d = '0;
      div_d   = load_div;
      mode_d  = load_mode;
    end else if (en_i) begin
      if (at_wrap) begin
        count_d = '0;
        div_d   = load_div;
        mode_d  = load_mode;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      clk_out_d = (mode_d == TICK_SQUARE) ? (count_d < (div_d >> 1)) : at_wrap;
    end

    if (cfg_we_i) begin
      sh_div_d  = wr_div;
      sh_mode_d = cfg_mode_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      div_q     <= DefDiv;
      sh_div_q  <= DefDiv;
      mode_q    <= TICK_PULSE;
      sh_mode_q <= TICK_PULSE;
      clk_out_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      sh_div_q  <= sh_div_d;
      mode_q    <= mode_d;
      sh_mode_q <= sh_mode_d;
      clk_out_q <= clk_out_d;
      wrap_q    <= wrap_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: decodes the config port to one
// channel and fans the global enable and restart out to every channel.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned DEF_DIV = 1_000_000,
  localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] wrap
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    // Out-of-range selects match no channel and are dropped.
    logic ch_we;
    assign ch_we = cfg_we && (cfg_sel == SEL_W'(i));

    tick_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .en_i       (en),
      .sync_clr_i (sync_clr),
      .cfg_we_i   (ch_we),
      .cfg_div_i  (cfg_div),
      .cfg_mode_i (tick_mode_e'(cfg_mode)),
      .clk_out_o  (clk_out[i]),
      .wrap_o     (wrap[i])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: period-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tick_gen_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DEFD = 10;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic           en;
  logic           sync_clr;
  logic           cfg_we;
  logic [1:0]     cfg_sel;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] wrap;

  int n_checks = 0;
  int n_pass   = 0;

  tick_gen_multi #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .DEF_DIV (DEFD)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .clk_out  (clk_out),
    .wrap     (wrap)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: position within the current period, active and pending
  // period length, and what the outputs must show after each edge.
  typedef struct {
    int pos;
    int n;
    int sh_n;
    bit sq;
    bit sh_sq;
    bit clk;
    bit wrp;
  } ch_t;

  ch_t m[NCH];

  function automatic ch_t reset_ch();
    ch_t r;
    r.pos = 0; r.n = DEFD; r.sh_n = DEFD; r.sq = 0; r.sh_sq = 0; r.clk = 0; r.wrp = 0;
    return r;
  endfunction

  function automatic ch_t step(input ch_t c, input bit hit, input int wn, input bit wm,
                               input bit sc, input bit e);
    ch_t r = c;
    if (sc) begin
      r.pos = 0;
      r.n   = hit ? wn : c.sh_n;
      r.sq  = hit ? wm : c.sh_sq;
      r.clk = 0;
      r.wrp = 0;
    end else if (e) begin
      r.pos = c.pos + 1;
      r.wrp = (r.pos == c.n);
      if (r.wrp) begin
        r.pos = 0;
        r.n   = hit ? wn : c.sh_n;
        r.sq  = hit ? wm : c.sh_sq;
      end
      r.clk = r.sq ? (r.pos < r.n / 2) : r.wrp;
    end else begin
      r.clk = 0;
      r.wrp = 0;
    end
    if (hit) begin
      r.sh_n  = wn;
      r.sh_sq = wm;
    end
    return r;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n) m[i] <= reset_ch();
      else m[i] <= step(m[i], cfg_we && (32'(cfg_sel) == i),
                        (int'(cfg_div) < 2) ? 2 : int'(cfg_div), cfg_mode, sync_clr, en);
    end
  end

  always @(negedge clk_in) begin
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("model_clk_out[%0d]", i), 32'(clk_out[i]), 32'(m[i].clk));
      check($sformatf("model_wrap[%0d]", i), 32'(wrap[i]), 32'(m[i].wrp));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic set_cfg(input bit we, input logic [1:0] sel, input logic [CW-1:0] div,
                         input bit mode);
    cfg_we = we; cfg_sel = sel; cfg_div = div; cfg_mode = mode;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (2) cyc();
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);

    // Default divisor, pulse mode, all channels in step.
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check("def_wrap", 32'(wrap), (k % 10 == 0) ? 32'd7 : 32'd0);
      check("def_pulse", 32'(clk_out), (k % 10 == 0) ? 32'd7 : 32'd0);
    end

    // Ch1 square div 7 loaded directly by a coincident restart.
    sync_clr = 1'b1; set_cfg(1, 1, 7, 1);
    cyc();
    sync_clr = 1'b0; set_cfg(0, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      cyc();
      check("sq7", 32'(clk_out[1]), ((k % 7) < 3) ? 32'd1 : 32'd0);
    end
    // Div 8 via shadow: takes over at the wrap on edge 21.
    set_cfg(1, 1, 8, 1);
    for (int k = 15; k <= 40; k++) begin
      cyc();
      if (k == 15) set_cfg(0, 0, 0, 0);
      if (k < 21) check("sq7_tail", 32'(clk_out[1]), ((k % 7) < 3) ? 32'd1 : 32'd0);
      else check("sq8", 32'(clk_out[1]), (((k - 21) % 8) < 4) ? 32'd1 : 32'd0);
    end

    // Ch2 div 4 written at count 3: current 10-period completes first.
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("ch2_retime", 32'(wrap[2]), (k == 10 || k == 14 || k == 18) ? 32'd1 : 32'd0);
      if (k == 3) set_cfg(1, 2, 4, 0);
      if (k == 4) set_cfg(0, 0, 0, 0);
    end

    // Div 0 and div 1 both clamp to 2.
    set_cfg(1, 0, 0, 0);
    cyc();
    set_cfg(1, 1, 1, 1); sync_clr = 1'b1;
    cyc();
    set_cfg(0, 0, 0, 0); sync_clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("div0_pulse", 32'(clk_out[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("div1_square", 32'(clk_out[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Enable dropped at count 6 of a 10-period.
    set_cfg(1, 2, 10, 0); sync_clr = 1'b1;
    cyc();
    set_cfg(0, 0, 0, 0); sync_clr = 1'b0;
    repeat (6) cyc();
    en = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("en_low_clk_out", 32'(clk_out), 32'd0);
      check("en_low_wrap", 32'(wrap), 32'd0);
    end
    en = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check("resume_wrap", 32'(wrap[2]), (j == 4) ? 32'd1 : 32'd0);
    end
    // Restart while disabled.
    en = 1'b0; sync_clr = 1'b1;
    cyc();
    check("sync_dis_clk_out", 32'(clk_out), 32'd0);
    sync_clr = 1'b0;
    cyc();
    check("sync_dis_wrap", 32'(wrap), 32'd0);
    en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      check("post_sync_ch2", 32'(wrap[2]), (j == 10) ? 32'd1 : 32'd0);
      check("post_sync_ch0", 32'(wrap[0]), (j % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Out-of-range select is ignored even with a coincident restart.
    set_cfg(1, 3, 5, 1); sync_clr = 1'b1;
    cyc();
    set_cfg(0, 0, 0, 0); sync_clr = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      check("badsel_ch2", 32'(wrap[2]), (j == 10) ? 32'd1 : 32'd0);
      check("badsel_ch1", 32'(clk_out[1]), (j % 2 == 0) ? 32'd1 : 32'd0);
      check("badsel_ch0", 32'(wrap[0]), (j % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset mid-period while an output is high.
    t = 0;
    while (clk_out[1] !== 1'b1 && t < 4) begin
      cyc();
      t++;
    end
    if (t == 4) check("wait_clk_out1_high", 32'd0, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_clk_out", 32'(clk_out), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("post_rst_wrap", 32'(wrap), (k == 10) ? 32'd7 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
